// File: rtl/clk_divider_prog_pkg.sv
// Shared constants for the programmable clock divider and the UART/SPI blocks
// that reuse its counter width.
package clk_divider_prog_pkg;

    // Default counter/period/high-time width for divider instances.
    localparam int unsigned CLK_DIV_CNT_W_DEFAULT = 16;

endpackage : clk_divider_prog_pkg

// File: rtl/clk_div_cfg.sv
// Configuration holder for clk_divider_prog: shadow registers for a requested
// period/high time, the pending-load flag, the apply decision and the ack pulse.
//
// Ports:
//   clkIn       system clock, rising edge
//   rstIn       synchronous active-high reset
//   loadIn      one-cycle strobe capturing periodIn/highIn into the shadow
//   periodIn    requested period
//   highIn      requested high time
//   applyOk     counter is at a period boundary or the divider is disabled
//   periodR     active period
//   highR       active high time
//   shadowHigh  captured high time waiting to be applied
//   applyNow_c  shadow is being applied on this edge (combinational)
//   loadAckOut  one-cycle pulse after the apply edge
module clk_div_cfg
    import clk_divider_prog_pkg::*;
#(
    parameter int unsigned CNT_W      = CLK_DIV_CNT_W_DEFAULT,
    parameter int unsigned DEF_PERIOD = 4,
    parameter int unsigned DEF_HIGH   = 2
) (
    input  logic             clkIn,
    input  logic             rstIn,
    input  logic             loadIn,
    input  logic [CNT_W-1:0] periodIn,
    input  logic [CNT_W-1:0] highIn,
    input  logic             applyOk,
    output logic [CNT_W-1:0] periodR,
    output logic [CNT_W-1:0] highR,
    output logic [CNT_W-1:0] shadowHigh,
    output logic             applyNow_c,
    output logic             loadAckOut
);

    logic [CNT_W-1:0] shadowPeriod;
    logic             pending;

    // A pending load takes effect only when the counter side says it is safe.
    assign applyNow_c = pending && applyOk;

    // Shadow capture, apply and ack; a load on the apply edge re-arms pending.
    always_ff @(posedge clkIn) begin
        if (rstIn) begin
            periodR      <= CNT_W'(DEF_PERIOD);
            highR        <= CNT_W'(DEF_HIGH);
            shadowPeriod <= '0;
            shadowHigh   <= '0;
            pending      <= 1'b0;
            loadAckOut   <= 1'b0;
        end else begin
            loadAckOut <= applyNow_c;
            if (applyNow_c) begin
                periodR <= shadowPeriod;
                highR   <= shadowHigh;
            end
            if (loadIn) begin
                shadowPeriod <= periodIn;
                shadowHigh   <= highIn;
                pending      <= 1'b1;
            end else if (applyNow_c) begin
                pending <= 1'b0;
            end
        end
    end

endmodule : clk_div_cfg

// File: rtl/clk_divider_prog.sv
// Runtime-programmable clock divider: divide-by-N with programmable high time,
// a period-start tick, and reconfiguration that only lands on a period boundary
// (or as a clean restart while disabled).
//
// Ports:
//   clkIn       system clock, rising edge
//   rstIn       synchronous active-high reset
//   enIn        count enable; low freezes the divider
//   periodIn    requested period in clkIn cycles (0 behaves as 1)
//   highIn      requested high time in clkIn cycles
//   loadIn      one-cycle strobe capturing periodIn/highIn
//   loadAckOut  one-cycle pulse: new settings now active
//   clkOut      registered divided clock
//   tickOut     one-cycle pulse at each period start
//   cntValOut   current phase count
module clk_divider_prog
    import clk_divider_prog_pkg::*;
#(
    parameter int unsigned CNT_W      = CLK_DIV_CNT_W_DEFAULT,
    parameter int unsigned DEF_PERIOD = 4,
    parameter int unsigned DEF_HIGH   = 2
) (
    input  logic             clkIn,
    input  logic             rstIn,
    input  logic             enIn,
    input  logic [CNT_W-1:0] periodIn,
    input  logic [CNT_W-1:0] highIn,
    input  logic             loadIn,
    output logic             loadAckOut,
    output logic             clkOut,
    output logic             tickOut,
    output logic [CNT_W-1:0] cntValOut
);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] periodR;
    logic [CNT_W-1:0] highR;
    logic [CNT_W-1:0] shadowHigh;
    logic             applyNow_c;
    logic             applyOk_c;
    logic             atLast_c;
    logic [CNT_W-1:0] lastCnt_c;
    logic [CNT_W-1:0] cntNext_c;
    logic [CNT_W-1:0] highEff_c;

    clk_div_cfg #(
        .CNT_W      (CNT_W),
        .DEF_PERIOD (DEF_PERIOD),
        .DEF_HIGH   (DEF_HIGH)
    ) u_cfg (
        .clkIn      (clkIn),
        .rstIn      (rstIn),
        .loadIn     (loadIn),
        .periodIn   (periodIn),
        .highIn     (highIn),
        .applyOk    (applyOk_c),
        .periodR    (periodR),
        .highR      (highR),
        .shadowHigh (shadowHigh),
        .applyNow_c (applyNow_c),
        .loadAckOut (loadAckOut)
    );

    // Phase arithmetic; period 0 is clamped to 1 so the subtraction never wraps.
    always_comb begin
        lastCnt_c = (periodR == '0) ? '0 : periodR - CNT_W'(1);
        atLast_c  = (cnt >= lastCnt_c);
        applyOk_c = !enIn || atLast_c;
        cntNext_c = atLast_c ? '0 : cnt + CNT_W'(1);
        // On an enabled apply edge the first new period already uses the new high time.
        highEff_c = applyNow_c ? shadowHigh : highR;
    end

    // Counter and registered outputs; disabled apply restarts at post-reset phase.
    always_ff @(posedge clkIn) begin
        if (rstIn) begin
            cnt     <= '0;
            clkOut  <= 1'b0;
            tickOut <= 1'b0;
        end else if (enIn) begin
            cnt     <= cntNext_c;
            clkOut  <= (cntNext_c < highEff_c);
            tickOut <= (cntNext_c == '0);
        end else begin
            tickOut <= 1'b0;
            if (applyNow_c) begin
                cnt    <= '0;
                clkOut <= 1'b0;
            end
        end
    end

    assign cntValOut = cnt;

endmodule : clk_divider_prog
